// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 64-bit RISC-V core: registers one decoded
// instruction, derives the ALU control code and operand selects, and resolves forwarding.
module id_ex_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [63:0] i_pc,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_5,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [63:0] i_rs1_data,
  input  logic [63:0] i_rs2_data,
  input  logic [63:0] i_imm,
  input  logic        i_exmem_wen,
  input  logic [4:0]  i_exmem_rd,
  input  logic [63:0] i_exmem_result,
  input  logic        i_memwb_wen,
  input  logic [4:0]  i_memwb_rd,
  input  logic [63:0] i_memwb_result,
  output logic        o_valid,
  output logic [3:0]  o_control,
  output logic [63:0] o_a,
  output logic [63:0] o_b,
  output logic [63:0] o_store_data,
  output logic [63:0] o_pc,
  output logic [63:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rd_addr,
  output logic        o_reg_wen,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;

  // Decoded next-slot values
  logic [3:0] dec_control;
  a_sel_e     dec_a_sel;
  b_sel_e     dec_b_sel;
  logic       dec_reg_wen, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_illegal;

  // Registered slot
  logic        valid_q, reg_wen_q, mem_read_q, mem_write_q, branch_q, jump_q, illegal_q;
  logic [3:0]  control_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [63:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
  a_sel_e      a_sel_q;
  b_sel_e      b_sel_q;

  logic [63:0] fwd_rs1, fwd_rs2;
  logic        wb_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_control   = 4'b0000;
    dec_a_sel     = A_RS1;
    dec_b_sel     = B_RS2;
    dec_reg_wen   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_illegal   = 1'b0;
    if (i_valid) begin
      unique case (i_opcode)
        OPC_OP: begin
          dec_control = {i_funct3, i_funct7_5};
          dec_reg_wen = 1'b1;
        end
        OPC_OP_IMM: begin
          dec_control = {i_funct3, (i_funct3 == 3'b101) & i_funct7_5};
          dec_b_sel   = B_IMM;
          dec_reg_wen = 1'b1;
        end
        OPC_LOAD: begin
          dec_b_sel    = B_IMM;
          dec_mem_read = 1'b1;
          dec_reg_wen  = 1'b1;
        end
        OPC_STORE: begin
          dec_b_sel     = B_IMM;
          dec_mem_write = 1'b1;
        end
        OPC_BRANCH: begin
          // Equality and signed/unsigned ordering all resolve off the ALU result
          if (!i_funct3[2])     dec_control = 4'b0001;
          else if (!i_funct3[1]) dec_control = 4'b0100;
          else                   dec_control = 4'b0110;
          dec_branch = 1'b1;
        end
        OPC_LUI: begin
          dec_a_sel   = A_ZERO;
          dec_b_sel   = B_IMM;
          dec_reg_wen = 1'b1;
        end
        OPC_AUIPC: begin
          dec_a_sel   = A_PC;
          dec_b_sel   = B_IMM;
          dec_reg_wen = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          // ALU computes the link address; the target is resolved elsewhere
          dec_a_sel   = A_PC;
          dec_b_sel   = B_FOUR;
          dec_jump    = 1'b1;
          dec_reg_wen = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign wb_hit = valid_q && i_memwb_wen && (i_memwb_rd != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      valid_q     <= 1'b0;
      reg_wen_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
      control_q   <= 4'b0000;
      funct3_q    <= 3'b000;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rd_addr_q   <= 5'd0;
      pc_q        <= 64'd0;
      imm_q       <= 64'd0;
      rs1_data_q  <= 64'd0;
      rs2_data_q  <= 64'd0;
      a_sel_q     <= A_RS1;
      b_sel_q     <= B_RS2;
    end else if (i_stall) begin
      // A producer retiring during the stall must not leave stale source data behind
      if (wb_hit && (i_memwb_rd == rs1_addr_q)) rs1_data_q <= i_memwb_result;
      if (wb_hit && (i_memwb_rd == rs2_addr_q)) rs2_data_q <= i_memwb_result;
    end else begin
      valid_q     <= i_valid;
      reg_wen_q   <= dec_reg_wen && (i_rd_addr != 5'd0);
      mem_read_q  <= dec_mem_read;
      mem_write_q <= dec_mem_write;
      branch_q    <= dec_branch;
      jump_q      <= dec_jump;
      illegal_q   <= dec_illegal;
      control_q   <= dec_control;
      funct3_q    <= i_funct3;
      rs1_addr_q  <= i_rs1_addr;
      rs2_addr_q  <= i_rs2_addr;
      rd_addr_q   <= i_rd_addr;
      pc_q        <= i_pc;
      imm_q       <= i_imm;
      rs1_data_q  <= i_rs1_data;
      rs2_data_q  <= i_rs2_data;
      a_sel_q     <= dec_a_sel;
      b_sel_q     <= dec_b_sel;
    end
  end

  // The younger producer (EX/MEM) takes priority over MEM/WB
  function automatic logic [63:0] forward(input logic [4:0] addr, input logic [63:0] data,
                                          input logic ex_wen, input logic [4:0] ex_rd,
                                          input logic [63:0] ex_res, input logic wb_wen,
                                          input logic [4:0] wb_rd, input logic [63:0] wb_res);
    if (ex_wen && (ex_rd != 5'd0) && (ex_rd == addr))      return ex_res;
    else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == addr)) return wb_res;
    else                                                   return data;
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_addr_q, rs1_data_q, i_exmem_wen, i_exmem_rd, i_exmem_result,
                      i_memwb_wen, i_memwb_rd, i_memwb_result);
    fwd_rs2 = forward(rs2_addr_q, rs2_data_q, i_exmem_wen, i_exmem_rd, i_exmem_result,
                      i_memwb_wen, i_memwb_rd, i_memwb_result);
    unique case (a_sel_q)
      A_PC:    o_a = pc_q;
      A_ZERO:  o_a = 64'd0;
      default: o_a = fwd_rs1;
    endcase
    unique case (b_sel_q)
      B_IMM:   o_b = imm_q;
      B_FOUR:  o_b = 64'd4;
      default: o_b = fwd_rs2;
    endcase
  end

  assign o_store_data = fwd_rs2;
  assign o_valid      = valid_q;
  assign o_control    = control_q;
  assign o_pc         = pc_q;
  assign o_imm        = imm_q;
  assign o_funct3     = funct3_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_reg_wen    = reg_wen_q;
  assign o_mem_read   = mem_read_q;
  assign o_mem_write  = mem_write_q;
  assign o_branch     = branch_q;
  assign o_jump       = jump_q;
  assign o_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected slots are queued when driven and
// compared one cycle later; forwarding and stall behaviour are checked in place.
module tb_id_ex_stage;

  logic        i_clk, i_rst, i_stall, i_flush, i_valid;
  logic [63:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic        i_funct7_5;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_exmem_wen, i_memwb_wen;
  logic [4:0]  i_exmem_rd, i_memwb_rd;
  logic [63:0] i_exmem_result, i_memwb_result;
  logic        o_valid, o_reg_wen, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal;
  logic [3:0]  o_control;
  logic [63:0] o_a, o_b, o_store_data, o_pc, o_imm;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rd_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [3:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic        chk_ab;
    logic        reg_wen;
    logic [4:0]  flags;  // {mem_read, mem_write, branch, jump, illegal}
  } exp_t;

  exp_t sb[$];

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_pc(i_pc), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7_5(i_funct7_5),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rd_addr(i_rd_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_exmem_wen(i_exmem_wen), .i_exmem_rd(i_exmem_rd), .i_exmem_result(i_exmem_result),
    .i_memwb_wen(i_memwb_wen), .i_memwb_rd(i_memwb_rd), .i_memwb_result(i_memwb_result),
    .o_valid(o_valid), .o_control(o_control), .o_a(o_a), .o_b(o_b),
    .o_store_data(o_store_data), .o_pc(o_pc), .o_imm(o_imm), .o_funct3(o_funct3),
    .o_rd_addr(o_rd_addr), .o_reg_wen(o_reg_wen), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic v, input logic [3:0] ctl,
                              input logic [63:0] a, input logic [63:0] b, input logic chk_ab,
                              input logic wen, input logic [4:0] flags);
    exp_t e;
    e.tag = tag; e.valid = v; e.control = ctl; e.a = a; e.b = b;
    e.chk_ab = chk_ab; e.reg_wen = wen; e.flags = flags;
    return e;
  endfunction

  task automatic idle_inputs();
    i_rst = 0; i_stall = 0; i_flush = 0; i_valid = 0; i_pc = '0; i_opcode = '0;
    i_funct3 = '0; i_funct7_5 = 0; i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_exmem_wen = 0; i_exmem_rd = '0; i_exmem_result = '0;
    i_memwb_wen = 0; i_memwb_rd = '0; i_memwb_result = '0;
  endtask

  task automatic load(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rs1, input logic [63:0] d1, input logic [4:0] rs2,
                      input logic [63:0] d2, input logic [4:0] rd, input logic [63:0] imm,
                      input logic [63:0] pc);
    i_valid = 1; i_opcode = opc; i_funct3 = f3; i_funct7_5 = f7;
    i_rs1_addr = rs1; i_rs1_data = d1; i_rs2_addr = rs2; i_rs2_data = d2;
    i_rd_addr = rd; i_imm = imm; i_pc = pc;
  endtask

  // Advance one edge, then pop the slot expected for it and compare
  task automatic step();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".valid"}, {63'd0, o_valid}, {63'd0, e.valid});
    check({e.tag, ".control"}, {60'd0, o_control}, {60'd0, e.control});
    check({e.tag, ".reg_wen"}, {63'd0, o_reg_wen}, {63'd0, e.reg_wen});
    check({e.tag, ".flags"}, {59'd0, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal},
          {59'd0, e.flags});
    if (e.chk_ab) begin
      check({e.tag, ".a"}, o_a, e.a);
      check({e.tag, ".b"}, o_b, e.b);
    end
  endtask

  initial begin
    idle_inputs();

    // Reset with a valid instruction presented
    i_rst = 1;
    load(7'b0110011, 3'b000, 1'b0, 5'd1, 64'd9, 5'd2, 64'd9, 5'd1, 64'd0, 64'd0);
    sb.push_back(mk("reset", 0, 4'b0000, 64'd0, 64'd0, 1, 0, 5'b00000));
    step();
    i_rst = 0;

    load(7'b0110011, 3'b000, 1'b1, 5'd1, 64'd5, 5'd2, 64'd3, 5'd3, 64'd0, 64'd0);
    sb.push_back(mk("op_sub", 1, 4'b0001, 64'd5, 64'd3, 1, 1, 5'b00000));
    step();

    load(7'b0010011, 3'b101, 1'b1, 5'd1, 64'h80, 5'd0, 64'd0, 5'd4, 64'd4, 64'd0);
    sb.push_back(mk("srai", 1, 4'b1011, 64'h80, 64'd4, 1, 1, 5'b00000));
    step();

    load(7'b0010011, 3'b000, 1'b1, 5'd1, 64'h80, 5'd0, 64'd0, 5'd4, 64'h123, 64'd0);
    sb.push_back(mk("addi", 1, 4'b0000, 64'h80, 64'h123, 1, 1, 5'b00000));
    step();

    load(7'b0000011, 3'b011, 1'b0, 5'd2, 64'h100, 5'd0, 64'd0, 5'd6, 64'h8, 64'd0);
    sb.push_back(mk("load", 1, 4'b0000, 64'h100, 64'h8, 1, 1, 5'b10000));
    step();

    load(7'b0100011, 3'b011, 1'b0, 5'd2, 64'h200, 5'd3, 64'h77, 5'd0, 64'h10, 64'd0);
    sb.push_back(mk("store", 1, 4'b0000, 64'h200, 64'h10, 1, 0, 5'b01000));
    step();
    check("store.data", o_store_data, 64'h77);

    load(7'b0110111, 3'b000, 1'b0, 5'd9, 64'h999, 5'd0, 64'd0, 5'd7, 64'h5000, 64'd0);
    sb.push_back(mk("lui", 1, 4'b0000, 64'd0, 64'h5000, 1, 1, 5'b00000));
    step();

    // Forwarding priority on rs1 = x7, rs2 = x8
    load(7'b0110011, 3'b000, 1'b0, 5'd7, 64'h11, 5'd8, 64'h22, 5'd10, 64'd0, 64'd0);
    sb.push_back(mk("fwd_base", 1, 4'b0000, 64'h11, 64'h22, 1, 1, 5'b00000));
    step();
    i_exmem_wen = 1; i_exmem_rd = 5'd7; i_exmem_result = 64'hAA;
    i_memwb_wen = 1; i_memwb_rd = 5'd7; i_memwb_result = 64'hBB;
    #1 check("fwd_exmem_wins", o_a, 64'hAA);
    i_exmem_wen = 0;
    #1 check("fwd_memwb", o_a, 64'hBB);
    i_memwb_rd = 5'd8;
    #1 check("fwd_store_rs2", o_store_data, 64'hBB);
    check("fwd_rs1_unmatched", o_a, 64'h11);
    i_exmem_wen = 1; i_exmem_rd = 5'd0; i_memwb_rd = 5'd0;
    #1 check("fwd_rd0_a", o_a, 64'h11);
    check("fwd_rd0_b", o_b, 64'h22);
    i_exmem_wen = 0; i_memwb_wen = 0;

    // Stall capture of a MEM/WB write to a held rs2
    load(7'b0110011, 3'b000, 1'b0, 5'd1, 64'd2, 5'd9, 64'd1, 5'd5, 64'd0, 64'd0);
    sb.push_back(mk("stall_base", 1, 4'b0000, 64'd2, 64'd1, 1, 1, 5'b00000));
    step();
    i_stall = 1;
    load(7'b1111111, 3'b111, 1'b1, 5'd3, 64'hDEAD, 5'd4, 64'hBEEF, 5'd6, 64'h1, 64'h1);
    i_memwb_wen = 1; i_memwb_rd = 5'd9; i_memwb_result = 64'h55;
    #1 check("stall_fwd_b", o_b, 64'h55);
    @(posedge i_clk);
    #1 i_memwb_wen = 0;
    #1 check("stall_capture_b", o_b, 64'h55);
    check("stall_hold_a", o_a, 64'd2);
    check("stall_hold_illegal", {63'd0, o_illegal}, 64'd0);
    check("stall_hold_rd", {59'd0, o_rd_addr}, 64'd5);
    @(posedge i_clk);
    #1 check("stall_capture_b2", o_b, 64'h55);
    check("stall_hold_valid", {63'd0, o_valid}, 64'd1);

    // Flush together with stall loads a bubble
    i_flush = 1;
    load(7'b0110011, 3'b000, 1'b1, 5'd1, 64'd5, 5'd2, 64'd3, 5'd3, 64'd0, 64'd0);
    sb.push_back(mk("flush_stall", 0, 4'b0000, 64'd0, 64'd0, 1, 0, 5'b00000));
    step();
    i_flush = 0; i_stall = 0;

    load(7'b1100011, 3'b110, 1'b0, 5'd1, 64'd7, 5'd2, 64'd9, 5'd0, 64'h40, 64'd0);
    sb.push_back(mk("bltu", 1, 4'b0110, 64'd7, 64'd9, 1, 0, 5'b00100));
    step();

    load(7'b1100011, 3'b100, 1'b0, 5'd1, 64'd7, 5'd2, 64'd9, 5'd0, 64'h40, 64'd0);
    sb.push_back(mk("blt", 1, 4'b0100, 64'd7, 64'd9, 1, 0, 5'b00100));
    step();

    load(7'b0010111, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd6, 64'h2000, 64'h1000);
    sb.push_back(mk("auipc", 1, 4'b0000, 64'h1000, 64'h2000, 1, 1, 5'b00000));
    step();

    // Reset during a stall discards the held slot
    i_stall = 1; i_rst = 1;
    sb.push_back(mk("rst_in_stall", 0, 4'b0000, 64'd0, 64'd0, 0, 0, 5'b00000));
    step();
    i_stall = 0; i_rst = 0;

    load(7'b1111111, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd5, 64'd0, 64'd0);
    sb.push_back(mk("illegal", 1, 4'b0000, 64'd0, 64'd0, 0, 0, 5'b00001));
    step();

    // JAL with rd = x0 must not write back
    load(7'b1101111, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'h80, 64'h40);
    sb.push_back(mk("jal_rd0", 1, 4'b0000, 64'h40, 64'd4, 1, 0, 5'b00010));
    step();

    load(7'b1100111, 3'b000, 1'b0, 5'd1, 64'd0, 5'd0, 64'd0, 5'd1, 64'h0, 64'h300);
    sb.push_back(mk("jalr", 1, 4'b0000, 64'h300, 64'd4, 1, 1, 5'b00010));
    step();

    // Slot loaded with i_valid low is a bubble
    load(7'b0110011, 3'b000, 1'b1, 5'd1, 64'd5, 5'd2, 64'd3, 5'd3, 64'd0, 64'd0);
    i_valid = 0;
    sb.push_back(mk("invalid_slot", 0, 4'b0000, 64'd0, 64'd0, 0, 0, 5'b00000));
    step();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
